hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble generation plus mult/div occupancy tracking
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        useRsD,
  input  logic        useRtD,
  input  logic        branchD,
  input  logic        mdUseD,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic        regwriteE,
  input  logic        memreadE,
  input  logic        memreadM,
  input  logic        md_startE,
  input  logic        md_divE,
  output logic        stallF,
  output logic        stallD,
  output logic        clrE,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_err,
  output logic [15:0] stall_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state, stateNext;
  logic [3:0] cnt, cntNext;
  logic       doneNext, matchE, matchM, lwStall, brStall, mdStall, stall;
  assign md_busy = (state == BUSY);
  // Hazard detection; register 0 never produces a dependency
  always_comb begin
    matchE  = regwriteE & (WriteRegE != 5'd0) &
              ((useRsD & (rsD == WriteRegE)) | (useRtD & (rtD == WriteRegE)));
    matchM  = memreadM & (WriteRegM != 5'd0) &
              ((useRsD & (rsD == WriteRegM)) | (useRtD & (rtD == WriteRegM)));
    lwStall = memreadE & matchE;
    brStall = branchD & (matchE | matchM);
    mdStall = mdUseD & (md_busy | md_startE);
    stall   = lwStall | brStall | mdStall;
    stallF  = stall;
    stallD  = stall;
    clrE    = stall;
  end
  // Mult/div occupancy FSM next state; a start while busy is dropped
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    doneNext  = 1'b0;
    if (state == IDLE) begin
      if (md_startE) begin
        stateNext = BUSY;
        cntNext   = md_divE ? 4'd10 : 4'd5;
      end
    end else if (cnt > 4'd1) begin
      cntNext = cnt - 4'd1;
    end else begin
      stateNext = IDLE;
      cntNext   = 4'd0;
      doneNext  = 1'b1;
    end
  end
  // State, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      md_done   <= 1'b0;
      md_err    <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      md_done <= doneNext;
      if (md_busy && md_startE) md_err <= 1'b1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0, rst_n;
  logic [4:0] rsD, rtD, WriteRegE, WriteRegM;
  logic useRsD, useRtD, branchD, mdUseD, regwriteE, memreadE, memreadM, md_startE, md_divE;
  logic stallF, stallD, clrE, md_busy, md_done, md_err;
  logic [15:0] stall_cnt;
  int errors = 0, checks = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .branchD(branchD), .mdUseD(mdUseD), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .regwriteE(regwriteE), .memreadE(memreadE), .memreadM(memreadM),
    .md_startE(md_startE), .md_divE(md_divE), .stallF(stallF), .stallD(stallD),
    .clrE(clrE), .md_busy(md_busy), .md_done(md_done), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    {rsD, rtD, WriteRegE, WriteRegM} = '0;
    {useRsD, useRtD, branchD, mdUseD, regwriteE, memreadE, memreadM, md_startE, md_divE} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({md_busy, md_done, md_err, stallD} !== 4'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: busy/done/err/stall=%b%b%b%b cnt=%h want 0000 0000",
               md_busy, md_done, md_err, stallD, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw_stall();
    do_reset();
    @(negedge clk);
    memreadE = 1; regwriteE = 1; WriteRegE = 5'd8; useRsD = 1; rsD = 5'd8;
    #1;
    checks++;
    if ({stallF, stallD, clrE} !== 3'b111) begin
      errors++; $display("FAIL lw_rs: stallF/D/clrE=%b want 111", {stallF, stallD, clrE});
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lw_cnt1: stall_cnt=%0d want 1", stall_cnt);
    end
    WriteRegE = 5'd0; rsD = 5'd0;
    #1;
    checks++;
    if ({stallF, stallD, clrE} !== 3'b000) begin
      errors++; $display("FAIL lw_reg0: stallF/D/clrE=%b want 000", {stallF, stallD, clrE});
    end
    WriteRegE = 5'd8; rsD = 5'd0; useRsD = 0; useRtD = 1; rtD = 5'd8;
    #1;
    checks++;
    if (stallD !== 1'b1) begin
      errors++; $display("FAIL lw_rt: stallD=%b want 1", stallD);
    end
    useRtD = 0;
    #1;
    checks++;
    if (stallD !== 1'b0) begin
      errors++; $display("FAIL lw_rt_unused: stallD=%b want 0", stallD);
    end
    useRtD = 1; memreadE = 0;
    @(negedge clk);
    checks++;
    if (stallD !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lw_nomem: stallD=%b cnt=%0d want 0 1", stallD, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_branch_stall();
    do_reset();
    @(negedge clk);
    branchD = 1; rtD = 5'd9; useRtD = 1; memreadM = 1; WriteRegM = 5'd9;
    #1;
    checks++;
    if ({stallF, stallD, clrE} !== 3'b111) begin
      errors++; $display("FAIL br_m: stallF/D/clrE=%b want 111", {stallF, stallD, clrE});
    end
    branchD = 0;
    #1;
    checks++;
    if (stallD !== 1'b0) begin
      errors++; $display("FAIL br_off: stallD=%b want 0", stallD);
    end
    branchD = 1; memreadM = 0; regwriteE = 1; WriteRegE = 5'd9;
    #1;
    checks++;
    if (stallD !== 1'b1) begin
      errors++; $display("FAIL br_e: stallD=%b want 1", stallD);
    end
    rtD = 5'd0; WriteRegE = 5'd0; WriteRegM = 5'd0; memreadM = 1;
    #1;
    checks++;
    if (stallD !== 1'b0) begin
      errors++; $display("FAIL br_reg0: stallD=%b want 0", stallD);
    end
    clear_inputs();
  endtask

  task automatic test_mult();
    do_reset();
    @(negedge clk);
    md_startE = 1; md_divE = 0; mdUseD = 1;
    #1;
    checks++;
    if (stallD !== 1'b1) begin
      errors++; $display("FAIL mult_start_stall: stallD=%b want 1", stallD);
    end
    @(negedge clk);
    md_startE = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checks++;
      if ({md_busy, md_done, stallD} !== 3'b101) begin
        errors++;
        $display("FAIL mult_busy%0d: busy/done/stall=%b want 101", i, {md_busy, md_done, stallD});
      end
      @(negedge clk);
    end
    mdUseD = 0;
    #1;
    checks++;
    if ({md_busy, md_done, md_err, stallD} !== 4'b0100 || stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL mult_done: busy/done/err/stall=%b cnt=%0d want 0100 6",
               {md_busy, md_done, md_err, stallD}, stall_cnt);
    end
    @(negedge clk);
    checks++;
    if ({md_busy, md_done} !== 2'b00) begin
      errors++; $display("FAIL mult_after: busy/done=%b want 00", {md_busy, md_done});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    md_startE = 1; md_divE = 0;
    @(negedge clk);
    md_startE = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (md_done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: md_done=%b want 1", md_done);
    end
    md_startE = 1; md_divE = 1;
    @(negedge clk);
    md_startE = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      checks++;
      if ({md_busy, md_done} !== 2'b10) begin
        errors++; $display("FAIL b2b_busy%0d: busy/done=%b want 10", i, {md_busy, md_done});
      end
      @(negedge clk);
    end
    checks++;
    if ({md_busy, md_done, md_err} !== 3'b010) begin
      errors++; $display("FAIL b2b_end: busy/done/err=%b want 010", {md_busy, md_done, md_err});
    end
    clear_inputs();
  endtask

  task automatic test_div_err();
    do_reset();
    @(negedge clk);
    md_startE = 1; md_divE = 1;
    @(negedge clk);
    md_startE = 0; md_divE = 0;
    for (int i = 1; i <= 10; i++) begin
      md_startE = (i == 3);
      #1;
      checks++;
      if (md_busy !== 1'b1 || md_err !== (i >= 4)) begin
        errors++;
        $display("FAIL div_err%0d: busy=%b err=%b want 1 %b", i, md_busy, md_err, i >= 4);
      end
      @(negedge clk);
    end
    md_startE = 0;
    #1;
    checks++;
    if ({md_busy, md_done, md_err} !== 3'b011) begin
      errors++; $display("FAIL div_err_end: busy/done/err=%b want 011", {md_busy, md_done, md_err});
    end
    @(negedge clk);
    checks++;
    if ({md_busy, md_done, md_err} !== 3'b001) begin
      errors++; $display("FAIL div_err_hold: busy/done/err=%b want 001", {md_busy, md_done, md_err});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    md_startE = 1; md_divE = 1; mdUseD = 1;
    @(negedge clk);
    md_startE = 0;
    @(negedge clk);
    md_startE = 1;
    @(negedge clk);
    md_startE = 0;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1 || md_err !== 1'b1 || stall_cnt !== 16'd4) begin
      errors++; $display("FAIL mid_pre: busy=%b err=%b cnt=%0d want 1 1 4", md_busy, md_err, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({md_busy, md_done, md_err, stallD} !== 4'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_async: busy/done/err/stall=%b cnt=%0d want 0000 0",
               {md_busy, md_done, md_err, stallD}, stall_cnt);
    end
    memreadE = 1; regwriteE = 1; WriteRegE = 5'd3; useRsD = 1; rsD = 5'd3;
    #1;
    checks++;
    if (stallD !== 1'b1) begin
      errors++; $display("FAIL mid_lw_in_reset: stallD=%b want 1", stallD);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({md_busy, md_done} !== 2'b00) begin
        errors++; $display("FAIL mid_post%0d: busy/done=%b want 00", i, {md_busy, md_done});
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    memreadE = 1; regwriteE = 1; WriteRegE = 5'd8; useRsD = 1; rsD = 5'd8;
    repeat (65534) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe: stall_cnt=%h want fffe", stall_cnt);
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff: stall_cnt=%h want ffff", stall_cnt);
    end
    repeat (4465) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: stall_cnt=%h want ffff", stall_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_branch_stall();
    test_mult();
    test_back_to_back();
    test_div_err();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
